cordic_req_sched: RTL and testbench
===================================

// Module: cordic_req_sched
// PURPOSE
//  Shares the 8-iteration CORDIC sin/cos datapath between N_REQ requesters.
//  - Round-robin arbitration, one job at a time.
//  - Sequences each job: holds the datapath in init, presents the angle, releases init,
//    waits for HALT (or times out), captures sin/cos.
//  - Returns the result with the requester ID over a valid/ready response port.
//  Sits between client logic and the CORDIC datapath, and drives its active-low init input.
// PARAMETERS
//  N_REQ    4   number of requesters (>=2)
//  ANGLE_W  8   angle/result width; the datapath is fixed at 8
//  TIMEOUT  16  RUN cycles without HALT before the job is aborted (>= ITERS+2)
//  ID_W     $clog2(N_REQ)  localparam, derived
// PORTS
//  CLK        in   1              system clock, rising edge
//  RESET      in   1              asynchronous, active-low
//  REQ_VALID  in   N_REQ          per-requester request valid
//  REQ_ANGLE  in   N_REQ*ANGLE_W  packed angles; requester i uses bits [i*ANGLE_W +: ANGLE_W]
//  REQ_READY  out  N_REQ          one-hot grant, combinational
//  DP_ANGLE   out  ANGLE_W        angle to the datapath, registered
//  DP_INIT_N  out  1              active-low datapath init (clears theta/sin/cos and the LUT pointer)
//  DP_HALT    in   1              datapath done
//  DP_COS     in   ANGLE_W        datapath cos result
//  DP_SIN     in   ANGLE_W        datapath sin result
//  RSP_VALID  out  1              response valid
//  RSP_READY  in   1              response accepted
//  RSP_ID     out  ID_W           index of the requester served
//  RSP_COS    out  ANGLE_W        captured cos
//  RSP_SIN    out  ANGLE_W        captured sin
//  RSP_ERR    out  1              1 = job timed out; COS/SIN are 0
//  BUSY       out  1              state != IDLE
// BEHAVIOUR
//  Reset (RESET=0, async):
//   - State IDLE; RR pointer 0; cycle counter 0.
//   - DP_INIT_N=0, DP_ANGLE=0, RSP_VALID=0, RSP_ID/COS/SIN=0, RSP_ERR=0, BUSY=0.
//   - Reset mid-job abandons the job silently; no response is produced.
//  States IDLE -> RUN -> RESP -> IDLE:
//   IDLE:
//    - DP_INIT_N=0, so the datapath is held cleared.
//    - REQ_READY = one-hot of the first REQ_VALID at or after the RR pointer, wrapping; 0 if none valid.
//    - On handshake with requester g: DP_ANGLE<=REQ_ANGLE[g]; RSP_ID<=g; pointer<=(g+1) mod N_REQ;
//      counter<=0; go to RUN.
//   RUN:
//    - DP_INIT_N=1; REQ_READY=0; counter increments every cycle.
//    - DP_HALT is ignored while counter==0 (stale-halt guard).
//    - DP_HALT=1 with counter>=1: RSP_COS<=DP_COS, RSP_SIN<=DP_SIN, RSP_ERR<=0, RSP_VALID<=1; go to RESP.
//    - Else if counter==TIMEOUT-1: RSP_COS/SIN<=0, RSP_ERR<=1, RSP_VALID<=1; go to RESP.
//    - If both conditions hold in the same cycle, HALT wins.
//   RESP:
//    - DP_INIT_N=0 (datapath re-cleared); RSP_* held stable while RSP_VALID=1 and RSP_READY=0.
//    - On RSP_READY=1: RSP_VALID<=0; go to IDLE.
//    - No new grant in that cycle; a grant can occur on the next cycle at the earliest.
//  Latency:
//   - Grant edge k -> datapath HALT rises after edge k+8 -> RSP_VALID=1 after edge k+9.
//   - Minimum occupancy: 11 cycles per job with RSP_READY tied high.
//  Fairness:
//   - A requester that keeps REQ_VALID asserted is granted within N_REQ jobs.
//   - Dropping REQ_VALID before the grant is legal; the request is then simply not served.
//  Widths:
//   - Angles are unsigned 0..255 = 0..360 deg.
//   - Results are passed through unmodified; there is no arithmetic in this block.
// STRUCTURE
//  - Shared header cordic_defs.vh: state encodings (IDLE/RUN/RESP), CORDIC_ITERS=8, ANGLE_W default.
//  - Sub-module rr_arbiter #(N): inputs REQ, ENABLE, PTR; outputs one-hot GNT and index GNT_IDX.
//    Combinational; the pointer register stays in this block.
//  - Everything else (FSM, counter, capture registers) lives in this module.
// TESTING
//  1. Single request: REQ_VALID=4'b0001, angle 32 -> grant next edge; RSP_VALID 9 cycles after grant;
//     RSP_ID=0, RSP_ERR=0, COS/SIN equal to the datapath outputs at HALT.
//  2. All four requesters valid, RSP_READY=1 -> grant order 0,1,2,3,0.
//     Requester 2 alone re-asserting after its grant waits behind 3.
//  3. Backpressure: RSP_READY=0 for 20 cycles -> RSP_* stable, REQ_READY=0, DP_INIT_N=0 throughout;
//     release -> IDLE next edge.
//  4. DP_HALT stuck at 0 -> RSP_ERR=1, COS=SIN=0 after exactly TIMEOUT RUN cycles (16).
//     DP_HALT=1 during RUN counter==0 -> ignored.
//  5. RESET low mid-RUN (counter=4) -> all outputs at reset values immediately (async).
//     RESET high -> IDLE, pointer 0, no response issued.
//  6. HALT and timeout coincide (TIMEOUT=9 bench override) -> RSP_ERR=0 with captured data.

Source files
------------

// File: rtl/cordic_req_sched_pkg.sv
// rtl/cordic_req_sched_pkg.sv - shared types and constants for the CORDIC request scheduler
package cordic_req_sched_pkg;

   localparam int CORDIC_ITERS = 8;
   localparam int ANGLE_W_DEF  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Index following idx in a ring of n entries.
   function automatic int next_idx(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cordic_req_sched_rr_arbiter.sv
// rtl/cordic_req_sched_rr_arbiter.sv - combinational round-robin arbiter, pointer held by caller
module cordic_req_sched_rr_arbiter
   import cordic_req_sched_pkg::*;
#(
   parameter  int N     = 4,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic             enable,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   // Scan from ptr upward, wrapping, and grant the first active request.
   always_comb begin
      logic [IDX_W-1:0] j;
      logic             found;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = ptr;
      for (int i = 0; i < N; i++) begin
         if (enable && !found && req[j]) begin
            gnt[j]  = 1'b1;
            gnt_idx = j;
            found   = 1'b1;
         end
         j = IDX_W'(next_idx(int'(j), N));
      end
   end

endmodule

// File: rtl/cordic_req_sched.sv
// rtl/cordic_req_sched.sv - shares one CORDIC sin/cos datapath among several requesters
module cordic_req_sched
   import cordic_req_sched_pkg::*;
#(
   parameter  int N_REQ   = 4,
   parameter  int ANGLE_W = ANGLE_W_DEF,
   parameter  int TIMEOUT = 2 * CORDIC_ITERS,
   localparam int ID_W    = $clog2(N_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*ANGLE_W-1:0] req_angle,
   output logic [N_REQ-1:0]         req_ready,
   output logic [ANGLE_W-1:0]       dp_angle,
   output logic                     dp_init_n,
   input  logic                     dp_halt,
   input  logic [ANGLE_W-1:0]       dp_cos,
   input  logic [ANGLE_W-1:0]       dp_sin,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [ANGLE_W-1:0]       rsp_cos,
   output logic [ANGLE_W-1:0]       rsp_sin,
   output logic                     rsp_err,
   output logic                     busy
);

   localparam int CNT_W = $clog2(TIMEOUT);

   state_t             state, state_nx;
   logic [ID_W-1:0]    ptr, gnt_idx;
   logic [N_REQ-1:0]   gnt;
   logic [CNT_W-1:0]   cnt;
   logic [ANGLE_W-1:0] sel_angle;
   logic               grant_en, take, halt_hit, to_hit, rsp_done;

   // Grants are only offered while idle, so RESP handshake cycles never grant.
   assign grant_en  = (state == ST_IDLE);
   assign req_ready = gnt;
   assign busy      = (state != ST_IDLE);

   cordic_req_sched_rr_arbiter #(.N(N_REQ)) u_arb (
      .req     (req_valid),
      .enable  (grant_en),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Pick the granted requester's angle slice.
   always_comb begin
      sel_angle = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_idx == ID_W'(i)) sel_angle = req_angle[i*ANGLE_W +: ANGLE_W];
      end
   end

   // Next-state logic; datapath is released from init only while a job runs.
   always_comb begin
      state_nx  = state;
      dp_init_n = 1'b0;
      take      = 1'b0;
      halt_hit  = 1'b0;
      to_hit    = 1'b0;
      rsp_done  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|gnt) begin
               take     = 1'b1;
               state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            dp_init_n = 1'b1;
            // A HALT seen on the first RUN cycle is left over from the previous job.
            if (dp_halt && cnt != '0) begin
               halt_hit = 1'b1;
               state_nx = ST_RESP;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               to_hit   = 1'b1;
               state_nx = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_done = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Job launch, cycle counter and response capture registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr       <= '0;
         cnt       <= '0;
         dp_angle  <= '0;
         rsp_id    <= '0;
         rsp_cos   <= '0;
         rsp_sin   <= '0;
         rsp_err   <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         if (take) begin
            dp_angle <= sel_angle;
            rsp_id   <= gnt_idx;
            ptr      <= ID_W'(next_idx(int'(gnt_idx), N_REQ));
            cnt      <= '0;
         end else if (state == ST_RUN) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (halt_hit) begin
            rsp_cos   <= dp_cos;
            rsp_sin   <= dp_sin;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
         end else if (to_hit) begin
            rsp_cos   <= '0;
            rsp_sin   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
         end else if (rsp_done) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cordic_req_sched.sv
// tb/tb_cordic_req_sched.sv - self-checking bench for cordic_req_sched with a fake datapath
module tb_cordic_req_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req_valid, req_valid9;
   logic [31:0] req_angle;
   logic [3:0] req_ready, req_ready9;
   logic [7:0] dp_angle, dp_angle9, dp_cos, dp_sin, dp_cos9, dp_sin9;
   logic       dp_init_n, dp_init_n9, dp_halt, dp_halt9;
   logic       rsp_valid, rsp_valid9, rsp_ready, rsp_ready9;
   logic [1:0] rsp_id, rsp_id9;
   logic [7:0] rsp_cos, rsp_sin, rsp_cos9, rsp_sin9;
   logic       rsp_err, rsp_err9, busy, busy9;

   int passes = 0;
   int total  = 0;
   int ptr_m  = 0;
   int hmode  = 0;
   logic [4:0] dcnt, dcnt9;

   always #5 clk = ~clk;

   cordic_req_sched dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_angle(req_angle),
      .req_ready(req_ready), .dp_angle(dp_angle), .dp_init_n(dp_init_n),
      .dp_halt(dp_halt), .dp_cos(dp_cos), .dp_sin(dp_sin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_err(rsp_err), .busy(busy)
   );

   cordic_req_sched #(.TIMEOUT(9)) dut9 (
      .clk(clk), .reset(reset), .req_valid(req_valid9), .req_angle(req_angle),
      .req_ready(req_ready9), .dp_angle(dp_angle9), .dp_init_n(dp_init_n9),
      .dp_halt(dp_halt9), .dp_cos(dp_cos9), .dp_sin(dp_sin9),
      .rsp_valid(rsp_valid9), .rsp_ready(rsp_ready9), .rsp_id(rsp_id9),
      .rsp_cos(rsp_cos9), .rsp_sin(rsp_sin9), .rsp_err(rsp_err9), .busy(busy9)
   );

   function automatic logic [7:0] fcos(input logic [7:0] a, input int n);
      return a + 8'(n * 7);
   endfunction

   function automatic logic [7:0] fsin(input logic [7:0] a, input int n);
      return a ^ 8'(n * 29);
   endfunction

   // Fake datapath: counts cycles since init release, halts after 8 iterations.
   always_ff @(posedge clk) begin
      if (!dp_init_n) dcnt <= 5'd0;
      else if (dcnt != 5'd31) dcnt <= dcnt + 5'd1;
      if (!dp_init_n9) dcnt9 <= 5'd0;
      else if (dcnt9 != 5'd31) dcnt9 <= dcnt9 + 5'd1;
   end

   // Halt behaviour selectable per test; outputs depend on the iteration count.
   always_comb begin
      case (hmode)
         1:       dp_halt = 1'b0;
         2:       dp_halt = dp_init_n;
         3:       dp_halt = dp_init_n && (dcnt == 5'd0);
         default: dp_halt = dp_init_n && (dcnt >= 5'd8);
      endcase
      dp_cos   = fcos(dp_angle, int'(dcnt));
      dp_sin   = fsin(dp_angle, int'(dcnt));
      dp_halt9 = dp_init_n9 && (dcnt9 >= 5'd8);
      dp_cos9  = fcos(dp_angle9, int'(dcnt9));
      dp_sin9  = fsin(dp_angle9, int'(dcnt9));
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One complete job: grant, run, optional backpressure, response handshake.
   task automatic serve_one(input logic [3:0] valid, input int mode, input int bp, output int gidx);
      int         exp_g, exp_lat, lat;
      logic [7:0] ang, ecos, esin;
      logic       eerr, ok;
      hmode     = mode;
      req_valid = valid;
      exp_g     = -1;
      for (int i = 0; i < 4; i++) begin
         if (exp_g < 0 && valid[(ptr_m + i) % 4]) exp_g = (ptr_m + i) % 4;
      end
      #1;
      check("grant", 32'(req_ready), 32'(1) << exp_g);
      gidx = -1;
      for (int i = 0; i < 4; i++) if (req_ready[i]) gidx = i;
      ang = req_angle[exp_g*8 +: 8];
      case (mode)
         1, 3:    begin exp_lat = 16; eerr = 1'b1; ecos = 8'd0; esin = 8'd0; end
         2:       begin exp_lat = 2;  eerr = 1'b0; ecos = fcos(ang, 1); esin = fsin(ang, 1); end
         default: begin exp_lat = 9;  eerr = 1'b0; ecos = fcos(ang, 8); esin = fsin(ang, 8); end
      endcase
      @(posedge clk); @(negedge clk);
      check("dp_angle", 32'(dp_angle), 32'(ang));
      lat = 0;
      ok  = 1'b1;
      while (!rsp_valid && lat < 40) begin
         if (req_ready !== 4'd0 || dp_init_n !== 1'b1 || busy !== 1'b1) ok = 1'b0;
         @(posedge clk); @(negedge clk);
         lat++;
      end
      check("run_state", 32'(ok), 32'd1);
      check("latency", lat, exp_lat);
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_id", 32'(rsp_id), exp_g);
      check("rsp_err", 32'(rsp_err), 32'(eerr));
      check("rsp_cos", 32'(rsp_cos), 32'(ecos));
      check("rsp_sin", 32'(rsp_sin), 32'(esin));
      ok = 1'b1;
      for (int c = 0; c <= bp; c++) begin
         if (c > 0) begin @(posedge clk); @(negedge clk); end
         if ({rsp_valid, rsp_id, rsp_cos, rsp_sin, rsp_err} !== {1'b1, 2'(exp_g), ecos, esin, eerr}
             || req_ready !== 4'd0 || dp_init_n !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      end
      check("resp_hold", 32'(ok), 32'd1);
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp_ready = 1'b0;
      check("back_idle", {30'd0, rsp_valid, busy}, 32'd0);
      ptr_m     = (exp_g + 1) % 4;
      req_valid = 4'd0;
   endtask

   initial begin
      int g, lat;
      int order[5] = '{0, 1, 2, 3, 0};
      reset      = 1'b0;
      req_valid  = 4'd0;
      req_valid9 = 4'd0;
      req_angle  = 32'd0;
      rsp_ready  = 1'b0;
      rsp_ready9 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {rsp_valid, rsp_err, busy, dp_init_n, req_ready}, 8'd0);
      check("reset_data", {rsp_id, rsp_cos, rsp_sin, dp_angle}, 26'd0);
      reset = 1'b1;

      // Single request from requester 0.
      req_angle = $urandom;
      req_angle[7:0] = 8'd32;
      serve_one(4'b0001, 0, 0, g);
      check("single_gidx", g, 0);

      // Async reset in the middle of a RUN phase.
      req_valid = 4'b0100;
      @(posedge clk); @(negedge clk);
      req_valid = 4'd0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("async_reset", {rsp_valid, rsp_err, busy, dp_init_n, rsp_id, dp_angle}, 14'd0);
      @(negedge clk);
      reset = 1'b1;
      ptr_m = 0;
      lat   = 0;
      repeat (20) begin
         @(posedge clk); @(negedge clk);
         if (rsp_valid !== 1'b0 || busy !== 1'b0) lat++;
      end
      check("no_rsp_after_reset", lat, 0);

      // All four persistent requesters: round-robin order from pointer 0.
      for (int k = 0; k < 5; k++) begin
         req_angle = $urandom;
         serve_one(4'b1111, 0, 0, g);
         check("rr_order", g, order[k]);
      end
      // Requester 2 re-requests right after service and waits behind 3.
      serve_one(4'b1100, 0, 0, g);
      check("rr_2_first", g, 2);
      serve_one(4'b1100, 0, 0, g);
      check("rr_3_next", g, 3);
      serve_one(4'b1100, 0, 0, g);
      check("rr_2_again", g, 2);

      // Backpressure for 20 cycles.
      req_angle = $urandom;
      serve_one(4'b0010, 0, 20, g);

      // Timeouts: HALT stuck low, and HALT only on the stale first RUN cycle.
      serve_one(4'b1000, 1, 0, g);
      serve_one(4'b0001, 3, 2, g);
      // HALT high throughout RUN: first cycle ignored, captured on the second.
      req_angle = $urandom;
      serve_one(4'b0110, 2, 0, g);

      // Request withdrawn before any clock edge is never granted.
      req_valid = 4'b0010;
      #2 req_valid = 4'd0;
      @(posedge clk); @(negedge clk);
      check("dropped_req", 32'(busy), 32'd0);

      // HALT coinciding with the last RUN cycle on the TIMEOUT=9 instance.
      req_angle  = $urandom;
      req_valid9 = 4'b0100;
      #1;
      check("t9_grant", 32'(req_ready9), 32'b0100);
      @(posedge clk); @(negedge clk);
      req_valid9 = 4'd0;
      lat = 0;
      while (!rsp_valid9 && lat < 30) begin
         @(posedge clk); @(negedge clk);
         lat++;
      end
      check("t9_latency", lat, 9);
      check("t9_err", 32'(rsp_err9), 32'd0);
      check("t9_id", 32'(rsp_id9), 32'd2);
      check("t9_cos", 32'(rsp_cos9), 32'(fcos(req_angle[23:16], 8)));
      check("t9_sin", 32'(rsp_sin9), 32'(fsin(req_angle[23:16], 8)));
      @(posedge clk); @(negedge clk);
      check("t9_idle", {30'd0, rsp_valid9, busy9}, 32'd0);

      // Randomised jobs against the round-robin reference model.
      for (int k = 0; k < 12; k++) begin
         req_angle = $urandom;
         serve_one(4'($urandom_range(1, 15)), 0, $urandom_range(0, 3), g);
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
